utm_tape: RTL and testbench
===========================

UTM_TAPE -- requirements
Module: utm_tape

Interface
REQ-001 SHALL have parameter TAPE_LEN, default 16: number of tape cells, power of two, head width = log2(TAPE_LEN).
REQ-002 SHALL have parameter HALT_STATE, default 3'b111: encoded core state that ends a run.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  begin a run; sampled only in IDLE, HALT or ERROR.
REQ-006 load_en / load_addr / load_sym  input  1 / log2(TAPE_LEN) / 3  tape preload write, accepted only in IDLE.
REQ-007 sym_out / sym_out_valid  output  3 / 1  symbol under head and its 1-cycle valid pulse, driving core sym_in / sym_in_valid.
REQ-008 core_done  input  1  core result strobe; new_sym, direction and encoded_next_state are valid in that cycle.
REQ-009 new_sym / direction / encoded_next_state  input  3 / 1 / 3  core result; direction 1 = right, 0 = left.
REQ-010 head  output  log2(TAPE_LEN)  current head position.
REQ-011 busy / halted / error  output  1 / 1 / 1  state flags.
REQ-012 step_count  output  16  completed steps of the current run.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, WRITE, HALT, ERROR.
REQ-014 IDLE/HALT/ERROR + start=1: head=0, step_count=0, halted=0, error=0, next state ISSUE.
REQ-015 ISSUE: sym_out = tape[head], sym_out_valid=1 for exactly this cycle, next state WAIT.
REQ-016 WAIT: hold until core_done=1, latch result, next state WRITE; core_done outside WAIT is ignored.
REQ-017 WRITE: tape[head] <= latched new_sym; head moves ±1; step_count increments, saturating at 16'hFFFF.
REQ-018 WRITE exit: latched state == HALT_STATE -> HALT (write and move still performed); else ISSUE.
REQ-019 Minimum step period: 3 cycles (ISSUE, WAIT with same-cycle core_done, WRITE).
REQ-020 Head boundary (left at 0, right at TAPE_LEN-1), macro absent: no write, head unchanged, step_count unchanged, enter ERROR.
REQ-021 busy=1 in ISSUE/WAIT/WRITE; halted=1 only in HALT; error=1 only in ERROR.
REQ-022 start while busy is ignored; load_en outside IDLE is ignored.
REQ-023 sym_out holds last driven value when sym_out_valid=0.

Reset
REQ-024 reset=0: state IDLE, head=0, step_count=0, sym_out=0, sym_out_valid=0, busy=halted=error=0.
REQ-025 reset mid-run aborts immediately to IDLE; tape cells are not cleared by reset.

Configuration
REQ-026 Macro UTM_TAPE_WRAP_EN defined: head wraps modulo TAPE_LEN at both ends, the boundary write occurs, and ERROR is unreachable.
REQ-027 Macro UTM_TAPE_WRAP_EN undefined: boundary behaviour per REQ-020.

Structure
REQ-028 Package utm_pkg SHALL hold SYM_W=3, STATE_W=3, HALT_STATE default, DIR_LEFT/DIR_RIGHT constants and the FSM state enum.
REQ-029 Tape storage SHALL be sub-module utm_tape_mem: TAPE_LEN x 3 register file, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-030 Preload cells 0..3 = 1,2,3,4; start; core returns new_sym=5, dir=1, state=0 each step -> cells 0..2 become 5, head=3 after 3 steps, step_count=3.
REQ-031 Core returns encoded_next_state=3'b111 on step 2 -> cell written, head moved, halted=1, busy=0, step_count=2, no further sym_out_valid.
REQ-032 Head=0, core returns dir=0 -> without macro: error=1, cell 0 unchanged, head=0; with UTM_TAPE_WRAP_EN: head=TAPE_LEN-1, cell 0 written.
REQ-033 core_done delayed 7 cycles after sym_out_valid -> exactly one sym_out_valid pulse per step, no write before core_done.
REQ-034 reset=0 asserted during WAIT -> next cycle IDLE, busy=0, head=0, previously written cells retained.
REQ-035 start and load_en pulsed while busy -> ignored; tape and step_count unaffected.

Source files
------------

// File: rtl/utm_pkg.sv
// rtl/utm_pkg.sv - shared widths, direction codes and FSM state encoding for the tape controller
package utm_pkg;

    localparam int SYM_W   = 3;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] HALT_STATE_DEFAULT = 3'b111;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERROR = 3'd5
    } fsm_state_e;

endpackage

// File: rtl/utm_tape_mem.sv
// rtl/utm_tape_mem.sv - tape register file, one synchronous write port, one asynchronous read port
module utm_tape_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 3
) (
    input  logic          clock_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    // Cells are deliberately unreset so tape contents survive a controller reset.
    logic [DW-1:0] mem_q [DEPTH];

    // Single write port; the controller guarantees at most one writer per cycle.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/utm_tape.sv
// rtl/utm_tape.sv - tape/head controller for a Turing core; UTM_TAPE_WRAP_EN makes the head wrap at both ends
module utm_tape
    import utm_pkg::*;
#(
    parameter int                  TAPE_LEN   = 16,
    parameter logic [STATE_W-1:0]  HALT_STATE = HALT_STATE_DEFAULT,
    localparam int                 HEAD_W     = $clog2(TAPE_LEN)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               load_en_i,
    input  logic [HEAD_W-1:0]  load_addr_i,
    input  logic [SYM_W-1:0]   load_sym_i,
    output logic [SYM_W-1:0]   sym_out_o,
    output logic               sym_out_valid_o,
    input  logic               core_done_i,
    input  logic [SYM_W-1:0]   new_sym_i,
    input  logic               direction_i,
    input  logic [STATE_W-1:0] encoded_next_state_i,
    output logic [HEAD_W-1:0]  head_o,
    output logic               busy_o,
    output logic               halted_o,
    output logic               error_o,
    output logic [15:0]        step_count_o
);

    fsm_state_e         state_q;
    logic [HEAD_W-1:0]  head_q;
    logic [15:0]        step_q;
    logic [SYM_W-1:0]   sym_q;
    logic               sym_vld_q;
    logic [SYM_W-1:0]   lat_sym_q;
    logic               lat_dir_q;
    logic [STATE_W-1:0] lat_state_q;

    logic [HEAD_W-1:0]  head_step_d;
    logic               blocked;
    logic               mem_we;
    logic [HEAD_W-1:0]  mem_waddr;
    logic [SYM_W-1:0]   mem_wdata;
    logic [HEAD_W-1:0]  rd_addr;
    logic [SYM_W-1:0]   rd_data;
    logic [SYM_W-1:0]   rd_sym;

    // Head position after the pending move; power-of-two length makes the arithmetic wrap for free.
    assign head_step_d = (lat_dir_q == DIR_RIGHT) ? head_q + HEAD_W'(1) : head_q - HEAD_W'(1);

`ifdef UTM_TAPE_WRAP_EN
    assign blocked = 1'b0;
`else
    logic at_edge;
    assign at_edge = ((lat_dir_q == DIR_LEFT)  && (head_q == '0)) ||
                     ((lat_dir_q == DIR_RIGHT) && (head_q == HEAD_W'(TAPE_LEN - 1)));
    assign blocked = at_edge;
`endif

    // Tape write: preload while idle, or the latched core symbol in WRITE unless the move is blocked.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = head_q;
        mem_wdata = lat_sym_q;
        if (reset_i) begin
            if (state_q == ST_IDLE) begin
                mem_we    = load_en_i;
                mem_waddr = load_addr_i;
                mem_wdata = load_sym_i;
            end else if (state_q == ST_WRITE) begin
                mem_we = !blocked;
            end
        end
    end

    // ISSUE is entered from a start (head 0) or from WRITE (moved head), so read ahead at that cell
    // and forward a same-cycle preload so the issued symbol is never stale.
    assign rd_addr = (state_q == ST_WRITE) ? head_step_d : '0;
    assign rd_sym  = (mem_we && (mem_waddr == rd_addr)) ? mem_wdata : rd_data;

    utm_tape_mem #(
        .DEPTH (TAPE_LEN),
        .AW    (HEAD_W),
        .DW    (SYM_W)
    ) u_mem (
        .clock_i (clock_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Step sequencer: the symbol/valid pair is registered on entry to ISSUE so valid lasts exactly that cycle.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            step_q      <= '0;
            sym_q       <= '0;
            sym_vld_q   <= 1'b0;
            lat_sym_q   <= '0;
            lat_dir_q   <= DIR_LEFT;
            lat_state_q <= '0;
        end else begin
            sym_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_HALT, ST_ERROR: begin
                    if (start_i) begin
                        head_q    <= '0;
                        step_q    <= '0;
                        sym_q     <= rd_sym;
                        sym_vld_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done_i) begin
                        lat_sym_q   <= new_sym_i;
                        lat_dir_q   <= direction_i;
                        lat_state_q <= encoded_next_state_i;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (blocked) begin
                        state_q <= ST_ERROR;
                    end else begin
                        head_q <= head_step_d;
                        step_q <= (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
                        if (lat_state_q == HALT_STATE) begin
                            state_q <= ST_HALT;
                        end else begin
                            sym_q     <= rd_sym;
                            sym_vld_q <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sym_out_o       = sym_q;
    assign sym_out_valid_o = sym_vld_q;
    assign head_o          = head_q;
    assign step_count_o    = step_q;
    assign busy_o          = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
    assign halted_o        = (state_q == ST_HALT);
    assign error_o         = (state_q == ST_ERROR);

endmodule

// File: tb/tb_utm_tape.sv
// tb/tb_utm_tape.sv - directed table-driven bench for utm_tape with a scripted core
module tb_utm_tape;
    import utm_pkg::*;

    localparam int TL = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [2:0]  load_sym;
    logic [2:0]  sym_out;
    logic        sym_out_valid;
    logic        core_done;
    logic [2:0]  new_sym;
    logic        direction;
    logic [2:0]  next_state;
    logic [3:0]  head;
    logic        busy;
    logic        halted;
    logic        error;
    logic [15:0] step_count;

    always #5 clk = ~clk;

    utm_tape #(.TAPE_LEN(TL)) dut (
        .clock_i              (clk),
        .reset_i              (reset_n),
        .start_i              (start),
        .load_en_i            (load_en),
        .load_addr_i          (load_addr),
        .load_sym_i           (load_sym),
        .sym_out_o            (sym_out),
        .sym_out_valid_o      (sym_out_valid),
        .core_done_i          (core_done),
        .new_sym_i            (new_sym),
        .direction_i          (direction),
        .encoded_next_state_i (next_state),
        .head_o               (head),
        .busy_o               (busy),
        .halted_o             (halted),
        .error_o              (error),
        .step_count_o         (step_count)
    );

    typedef struct {
        int start;
        int nsym;
        int dir;
        int nst;
        int dly;
        int exp_in;
        int exp_head;
        int exp_step;
        int exp_halt;
        int exp_err;
        int cell_a;
        int cell_v;
    } vec_t;

    int       checks = 0;
    int       errors = 0;
    logic [2:0] tape_m [TL];
    vec_t     vecs [7];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_state(input int idx);
        chk("rst_busy", idx, busy, 0);
        chk("rst_halted", idx, halted, 0);
        chk("rst_error", idx, error, 0);
        chk("rst_head", idx, head, 0);
        chk("rst_step", idx, step_count, 0);
        chk("rst_valid", idx, sym_out_valid, 0);
    endtask

    // Entered with the DUT in ISSUE; plays the core for one step and checks the outcome.
    task automatic do_step(input vec_t v, input int idx);
        chk("issue_valid", idx, sym_out_valid, 1);
        chk("issue_sym", idx, sym_out, v.exp_in);
        tick();
        chk("hold_sym", idx, sym_out, v.exp_in);
        for (int d = 0; d < v.dly; d++) begin
            chk("wait_valid", idx, sym_out_valid, 0);
            chk("wait_nowrite", idx, dut.u_mem.mem_q[v.cell_a], tape_m[v.cell_a]);
            tick();
        end
        core_done  = 1'b1;
        new_sym    = 3'(v.nsym);
        direction  = 1'(v.dir);
        next_state = 3'(v.nst);
        tick();
        core_done  = 1'b0;
        chk("write_valid", idx, sym_out_valid, 0);
        tick();
        tape_m[v.cell_a] = 3'(v.cell_v);
        chk("head", idx, head, v.exp_head);
        chk("step", idx, step_count, v.exp_step);
        chk("halted", idx, halted, v.exp_halt);
        chk("error", idx, error, v.exp_err);
        chk("busy", idx, busy, (v.exp_halt == 0 && v.exp_err == 0) ? 1 : 0);
        chk("cell", idx, dut.u_mem.mem_q[v.cell_a], v.cell_v);
        if (v.exp_halt != 0 || v.exp_err != 0) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("post_end_valid", idx, sym_out_valid, 0);
            end
        end
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = '0; load_sym = '0;
        core_done = 1'b0; new_sym = '0; direction = 1'b0; next_state = '0;

        //            st sym dir nst dly in head step halt err a  v
        vecs[0] = '{1, 5, 1, 0, 0, 1, 1, 1, 0, 0, 0, 5};
        vecs[1] = '{0, 5, 1, 0, 0, 2, 2, 2, 0, 0, 1, 5};
        vecs[2] = '{0, 5, 1, 0, 0, 3, 3, 3, 0, 0, 2, 5};
        vecs[3] = '{0, 6, 1, 7, 7, 4, 4, 4, 1, 0, 3, 6};
        vecs[4] = '{1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1};
        vecs[5] = '{0, 2, 1, 7, 2, 5, 2, 2, 1, 0, 1, 2};
`ifdef UTM_TAPE_WRAP_EN
        vecs[6] = '{1, 7, 0, 7, 0, 1, 15, 1, 1, 0, 0, 7};
`else
        vecs[6] = '{1, 7, 0, 7, 0, 1, 0, 0, 0, 1, 0, 1};
`endif

        tick();
        tick();
        chk_reset_state(0);
        chk("rst_sym", 0, sym_out, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < TL; i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_sym  = (i < 4) ? 3'(i + 1) : 3'd0;
            tape_m[i] = load_sym;
            tick();
        end
        load_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("preload", i, dut.u_mem.mem_q[i], i + 1);
        end

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].start != 0) begin
                do_start();
            end
            do_step(vecs[i], i);
        end

        // Walk the head to the right end, then try to step past it.
        do_start();
        for (int i = 0; i < TL - 1; i++) begin
            v = '{0, 3, 1, 0, 0, int'(tape_m[i]), i + 1, i + 1, 0, 0, i, 3};
            do_step(v, 100 + i);
        end
`ifdef UTM_TAPE_WRAP_EN
        v = '{0, 3, 1, 0, 0, int'(tape_m[TL-1]), 0, TL, 0, 0, TL - 1, 3};
`else
        v = '{0, 3, 1, 0, 0, int'(tape_m[TL-1]), TL - 1, TL - 1, 0, 1, TL - 1, int'(tape_m[TL-1])};
`endif
        do_step(v, 200);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_state(1);

        // Reset in the middle of WAIT aborts the run but keeps the tape.
        do_start();
        v = '{0, 4, 1, 0, 0, int'(tape_m[0]), 1, 1, 0, 0, 0, 4};
        do_step(v, 300);
        tick();
        chk("midrun_busy_before", 0, busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_state(2);
        chk("midrun_cell0", 0, dut.u_mem.mem_q[0], 4);

        // start and load_en while busy are ignored.
        do_start();
        chk("busy_issue_sym", 0, sym_out, tape_m[0]);
        tick();
        start = 1'b1; load_en = 1'b1; load_addr = 4'd1; load_sym = 3'd7;
        tick();
        start = 1'b0; load_en = 1'b0;
        chk("busy_load_ignored", 0, dut.u_mem.mem_q[1], tape_m[1]);
        chk("busy_step", 0, step_count, 0);
        chk("busy_still", 0, busy, 1);
        core_done = 1'b1; new_sym = 3'd6; direction = 1'b1; next_state = 3'd0;
        tick();
        core_done = 1'b0;
        tick();
        chk("busy_head", 0, head, 1);
        chk("busy_step_after", 0, step_count, 1);
        chk("busy_cell0", 0, dut.u_mem.mem_q[0], 6);
        chk("busy_cell1", 0, dut.u_mem.mem_q[1], tape_m[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
